// File: rtl/pu_regfile_sb.sv
// Per-PU register file with two write ports (ALU and load writeback) and a per-register busy scoreboard.
// Optional build macro PU_REGFILE_BYPASS_EN adds same-cycle write-to-read forwarding on both read ports.
module pu_regfile_sb #(
   parameter int WIDTH  = 16,
   parameter int DEPTH  = 4,
   parameter int PU_NUM = 0,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [AW-1:0]    arad,
   input  logic [AW-1:0]    brad,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   output logic             a_busy,
   output logic             b_busy,
   input  logic             we,
   input  logic [AW-1:0]    wad,
   input  logic [WIDTH-1:0] wd,
   input  logic             lock,
   input  logic [AW-1:0]    lad,
   input  logic             lwe,
   input  logic [AW-1:0]    lwad,
   input  logic [WIDTH-1:0] lwd,
   output logic [DEPTH-1:0] busy_vec,
   output logic             err
);

   logic [WIDTH-1:0] regs_q [DEPTH];
   logic [WIDTH-1:0] regs_d [DEPTH];
   logic [DEPTH-1:0] busy_q;
   logic [DEPTH-1:0] busy_d;
   logic             err_q;
   logic             err_d;
   logic             hazard_s;

   // Next-state: ALU write first, load writeback second so it wins, lock last (clear-then-set).
   always_comb begin
      regs_d   = regs_q;
      busy_d   = busy_q;
      hazard_s = 1'b0;
      if (we) begin
         if (!busy_q[wad]) begin
            regs_d[wad] = wd;
         end else begin
            hazard_s = 1'b1;
         end
      end else begin
         hazard_s = hazard_s;
      end
      if (lwe) begin
         regs_d[lwad] = lwd;
         busy_d[lwad] = 1'b0;
         if (!busy_q[lwad]) begin
            hazard_s = 1'b1;
         end else begin
            hazard_s = hazard_s;
         end
      end else begin
         hazard_s = hazard_s;
      end
      if (lock) begin
         busy_d[lad] = 1'b1;
         if (busy_q[lad] && !(lwe && (lwad == lad))) begin
            hazard_s = 1'b1;
         end else begin
            hazard_s = hazard_s;
         end
      end else begin
         hazard_s = hazard_s;
      end
      err_d = err_q | hazard_s;
   end

   // State registers; reset drops every pending lock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= (i == 0) ? WIDTH'(PU_NUM) : {WIDTH{1'b0}};
         end
         busy_q <= {DEPTH{1'b0}};
         err_q  <= 1'b0;
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
         err_q  <= err_d;
      end
   end

   // Read ports; the forwarding build lets a returning load also clear the reported busy bit.
   always_comb begin
      a      = regs_q[arad];
      b      = regs_q[brad];
      a_busy = busy_q[arad];
      b_busy = busy_q[brad];
`ifdef PU_REGFILE_BYPASS_EN
      if (lwe && (lwad == arad)) begin
         a      = lwd;
         a_busy = 1'b0;
      end else if (we && (wad == arad) && !busy_q[wad]) begin
         a = wd;
      end else begin
         a = regs_q[arad];
      end
      if (lwe && (lwad == brad)) begin
         b      = lwd;
         b_busy = 1'b0;
      end else if (we && (wad == brad) && !busy_q[wad]) begin
         b = wd;
      end else begin
         b = regs_q[brad];
      end
`endif
   end

   assign busy_vec = busy_q;
   assign err      = err_q;

endmodule

// File: doc/pu_regfile_sb.md
Name: pu_regfile_sb

Overview:
- Parametrised per-PU register file: successor to the fixed 4-entry, 2-read/1-write PU register array.
- Adds configurable width and depth, a second write port for delayed load writeback, and a per-register scoreboard (busy bits) so the PU sequencer can stall on pending loads.
- Sits between the PU decode stage (read ports, lock requests), the ALU writeback and the memory-response writeback.

Parameters:
- WIDTH, 16, data width in bits.
- DEPTH, 4, number of registers (power of two, ≥2).
- PU_NUM, 0, PU index; reset value of register 0, zero-extended to WIDTH.
- AW, $clog2(DEPTH), address width (derived; not overridden).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- arad  in  AW  read address A.
- brad  in  AW  read address B.
- a  out  WIDTH  read data A.
- b  out  WIDTH  read data B.
- a_busy  out  1  scoreboard bit of register arad.
- b_busy  out  1  scoreboard bit of register brad.
- we  in  1  ALU write enable.
- wad  in  AW  ALU write address.
- wd  in  WIDTH  ALU write data.
- lock  in  1  mark register lad pending (load issued).
- lad  in  AW  lock address.
- lwe  in  1  load writeback enable.
- lwad  in  AW  load writeback address.
- lwd  in  WIDTH  load writeback data.
- busy_vec  out  DEPTH  all scoreboard bits, bit i = register i.
- err  out  1  sticky hazard error.

Behaviour:
- Reset (async, while rst=1):
  - reg[0]=PU_NUM; reg[1..DEPTH-1]=0.
  - busy_vec=0; err=0.
  - Reset mid-operation discards all pending locks.
- Reads: combinational, zero latency.
  - a=reg[arad], b=reg[brad].
  - a_busy=busy[arad], b_busy=busy[brad] (registered state, pre-edge).
- Register state updates only on posedge clk with rst=0. Both writes and all scoreboard changes are visible on the cycle after the edge.
- ALU write, we=1:
  - busy[wad]=0: reg[wad]<=wd.
  - busy[wad]=1 and not (lwe=1 and lwad=wad): write dropped (WAW hazard), err<=1.
  - busy[wad]=1 and lwe=1 and lwad=wad: load writeback wins; ALU write dropped; err<=1.
- Load write, lwe=1:
  - reg[lwad]<=lwd; busy[lwad]<=0.
  - lwe to a non-busy register still writes, and sets err<=1 (spurious response).
- Lock, lock=1:
  - Normally busy[lad]<=1.
  - lock to an already-busy register with no same-cycle lwe to lad: err<=1, busy stays 1.
  - Same cycle lwe=1, lwad=lad: clear then set, so busy stays 1, data written, no error.
- we and lwe to different addresses in the same cycle: both writes occur.
- Register 0 is writable like any other; no hardwired zero.
- err is sticky until rst. Multiple hazard sources in one cycle produce one set.
- Addresses are always in range (DEPTH power of two); no bounds check.

Optional Feature:
- Macro: PU_REGFILE_BYPASS_EN.
- Defined: same-cycle write-to-read forwarding.
  - If lwe=1 and lwad==arad, a=lwd and a_busy=0.
  - Else if we=1, wad==arad and busy[wad]=0, a=wd.
  - Same rules for port B with brad.
  - The a_busy=0 override covers a pending load returning this cycle.
- Undefined: reads return only registered state; the read-after-write penalty is one cycle. Registered behaviour is identical in both builds.

Test Plan:
- Async reset, PU_NUM=2, WIDTH=16, DEPTH=4 -> reg0=0x0002, reg1..3=0, busy_vec=0000, err=0, asserted without any clock edge.
- we=1, wad=3, wd=0xBEEF; next cycle arad=3 -> a=0xBEEF, a_busy=0; with PU_REGFILE_BYPASS_EN, a=0xBEEF already in the write cycle.
- lock=1, lad=1 -> busy_vec=0010, b_busy=1 with brad=1. Three cycles later, lwe=1, lwad=1, lwd=0x1234 -> busy_vec=0000, reg1=0x1234, err=0.
- Register 2 busy; we=1, wad=2, wd=0x5555 -> reg2 unchanged, err=1 and stays 1 until rst.
- Register 1 busy; lwe=1, lwad=1 and lock=1, lad=1 in the same cycle -> reg1=lwd, busy_vec[1]=1, err=0.
- Lock register 3, assert rst mid-pending -> busy_vec=0000, reg3=0, err=0. A subsequent lwe to register 3 then sets err=1.
